// File: rtl/signal_pkg.sv
// Shared types and constants for the signal_shrink window decoder.
package signal_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CNT,
        WAIT_LOW
    } shrink_st_e;

    localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/signal_shrink_sat_cnt.sv
// Saturating event counter with synchronous clear; clear beats a same-cycle increment.
// Only present when SIGNAL_SHRINK_STAT_EN is defined.
`ifdef SIGNAL_SHRINK_STAT_EN
module sat_cnt #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule
`endif

// File: rtl/signal_shrink.sv
// Recovers a single-cycle valid pulse from a stretched valid level and qualifies the window width/data.
// Define SIGNAL_SHRINK_STAT_EN to add the saturating error counter (i_err_cnt_clr / o_err_cnt).
module signal_shrink
    import signal_pkg::*;
#(
    parameter int EXTEND_CYC_NUM = 12,
    parameter int TOL_CYC_NUM    = 1,
    parameter int END_OF_LIST    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
`ifdef SIGNAL_SHRINK_STAT_EN
    input  logic                 i_err_cnt_clr,
    output logic [ERR_CNT_W-1:0] o_err_cnt,
`endif
    input  logic                 i_vld,
    input  logic                 i_vld_data,
    output logic                 o_vld,
    output logic                 o_vld_data,
    output logic                 o_err_short,
    output logic                 o_err_long,
    output logic                 o_err_data,
    output logic                 o_busy
);

    localparam int CNT_W = $clog2(EXTEND_CYC_NUM + TOL_CYC_NUM + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(EXTEND_CYC_NUM + TOL_CYC_NUM);
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(EXTEND_CYC_NUM - TOL_CYC_NUM);

    shrink_st_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             data_q, data_d;
    logic             data_err_q, data_err_d;
    logic             vld_q, vld_d;
    logic             vld_data_q, vld_data_d;
    logic             err_short_q, err_short_d;
    logic             err_long_q, err_long_d;
    logic             err_data_q, err_data_d;
    logic             busy_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        data_err_d  = data_err_q;
        vld_d       = 1'b0;
        vld_data_d  = 1'b0;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        err_data_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_vld) begin
                    cnt_d      = CNT_W'(1);
                    data_d     = i_vld_data;
                    data_err_d = 1'b0;
                    state_d    = CNT;
                end
            end
            CNT: begin
                if (i_vld) begin
                    if (i_vld_data != data_q) begin
                        data_err_d = 1'b1;
                    end
                    // Window overran the band: report once, then ignore the rest of it.
                    if (cnt_q == CNT_MAX) begin
                        err_long_d = 1'b1;
                        state_d    = WAIT_LOW;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    if (cnt_q < CNT_MIN) begin
                        err_short_d = 1'b1;
                    end else if (data_err_q) begin
                        err_data_d = 1'b1;
                    end else begin
                        vld_d      = 1'b1;
                        vld_data_d = data_q;
                    end
                    state_d = IDLE;
                end
            end
            WAIT_LOW: begin
                if (!i_vld) begin
                    state_d = IDLE;
                end
            end
            default: state_d = WAIT_LOW;
        endcase
    end

    // Reset parks in WAIT_LOW so a window already in flight is never decoded.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= WAIT_LOW;
            cnt_q       <= '0;
            data_q      <= 1'b0;
            data_err_q  <= 1'b0;
            vld_q       <= 1'b0;
            vld_data_q  <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            err_data_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            data_err_q  <= data_err_d;
            vld_q       <= vld_d;
            vld_data_q  <= vld_data_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            err_data_q  <= err_data_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    assign o_vld       = vld_q;
    assign o_vld_data  = vld_data_q;
    assign o_err_short = err_short_q;
    assign o_err_long  = err_long_q;
    assign o_err_data  = err_data_q;
    assign o_busy      = busy_q;

`ifdef SIGNAL_SHRINK_STAT_EN
    sat_cnt #(
        .W(ERR_CNT_W)
    ) u_err_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_err_cnt_clr),
        .i_inc (err_short_q | err_long_q | err_data_q),
        .o_cnt (o_err_cnt)
    );
`endif

endmodule

// File: tb/tb_signal_shrink.sv
// Randomized self-checking bench for signal_shrink against a window-level reference model.
module tb_signal_shrink;

    localparam int EXT  = 12;
    localparam int TOL  = 1;
    localparam int MAXW = EXT + TOL;
    localparam int MINW = EXT - TOL;

    logic clk = 1'b0;
    logic rst;
    logic vld;
    logic vldData;
    logic oVld, oVldData, oErrShort, oErrLong, oErrData, oBusy;
`ifdef SIGNAL_SHRINK_STAT_EN
    logic       errCntClr;
    logic [7:0] oErrCnt;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: the window is kept as the list of sampled data bits.
    bit mWait;
    bit mIn;
    bit mQ[$];
    bit eVld, eData, eShort, eLong, eErrData, eBusy;
    bit prevErr;
    int eCnt;

    signal_shrink #(
        .EXTEND_CYC_NUM(EXT),
        .TOL_CYC_NUM   (TOL),
        .END_OF_LIST   (1)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
`ifdef SIGNAL_SHRINK_STAT_EN
        .i_err_cnt_clr(errCntClr),
        .o_err_cnt    (oErrCnt),
`endif
        .i_vld        (vld),
        .i_vld_data   (vldData),
        .o_vld        (oVld),
        .o_vld_data   (oVldData),
        .o_err_short  (oErrShort),
        .o_err_long   (oErrLong),
        .o_err_data   (oErrData),
        .o_busy       (oBusy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelStep(input bit r, input bit v, input bit d);
        int  w;
        bit  stable;
        eVld = 0; eData = 0; eShort = 0; eLong = 0; eErrData = 0;
        if (r) begin
            mWait = 1; mIn = 0; mQ.delete();
            eBusy = 0; eCnt = 0; prevErr = 0;
            return;
        end
        if (prevErr && eCnt < 255) eCnt++;
        if (mWait) begin
            if (!v) mWait = 0;
        end else if (!mIn) begin
            if (v) begin
                mIn = 1;
                mQ.delete();
                mQ.push_back(d);
            end
        end else if (v) begin
            mQ.push_back(d);
            if (mQ.size() > MAXW) begin
                eLong = 1; mWait = 1; mIn = 0;
            end
        end else begin
            w = mQ.size();
            stable = 1;
            foreach (mQ[k]) if (mQ[k] != mQ[0]) stable = 0;
            if (w < MINW) eShort = 1;
            else if (!stable) eErrData = 1;
            else begin eVld = 1; eData = mQ[0]; end
            mIn = 0;
        end
        eBusy = mWait || mIn;
        prevErr = eShort || eLong || eErrData;
    endtask

    task automatic applyStimulus(input bit r, input bit v, input bit d);
        rst = r; vld = v; vldData = d;
        @(posedge clk);
        modelStep(r, v, d);
        @(negedge clk);
        checkOutput("vld",      8'(oVld),      8'(eVld));
        checkOutput("vld_data", 8'(oVldData),  8'(eData));
        checkOutput("err_short",8'(oErrShort), 8'(eShort));
        checkOutput("err_long", 8'(oErrLong),  8'(eLong));
        checkOutput("err_data", 8'(oErrData),  8'(eErrData));
        checkOutput("busy",     8'(oBusy),     8'(eBusy));
`ifdef SIGNAL_SHRINK_STAT_EN
        checkOutput("err_cnt",  oErrCnt,       8'(eCnt));
`endif
    endtask

    // High window of len samples; data flips from sample togAt onward when togAt > 0.
    task automatic sendWindow(input int len, input bit d, input int togAt);
        for (int i = 0; i < len; i++) begin
            applyStimulus(0, 1, (togAt > 0 && i >= togAt) ? ~d : d);
        end
        applyStimulus(0, 0, 0);
    endtask

    initial begin
        int len;
        int tog;
        int gap;
        bit d;
        rst = 1; vld = 0; vldData = 0;
`ifdef SIGNAL_SHRINK_STAT_EN
        errCntClr = 0;
`endif
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);

        sendWindow(12, 1, 0);
        sendWindow(11, 0, 0);
        sendWindow(13, 0, 0);
        sendWindow(10, 1, 0);
        sendWindow(20, 1, 0);
        sendWindow(12, 1, 0);
        sendWindow(12, 0, 6);

        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1);
        applyStimulus(1, 1, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1);
        applyStimulus(0, 0, 0);
        sendWindow(12, 1, 0);

        sendWindow(12, 0, 0);
        sendWindow(12, 1, 0);
        sendWindow(1, 1, 0);
        sendWindow(14, 0, 0);

        for (int n = 0; n < 60; n++) begin
            len = $urandom_range(1, 20);
            d   = 1'($urandom % 2);
            tog = ($urandom % 4 == 0) ? $urandom_range(1, len) : 0;
            sendWindow(len, d, tog);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) applyStimulus(0, 0, 0);
            if ($urandom % 10 == 0) applyStimulus(1, 1'($urandom % 2), 0);
        end
        applyStimulus(0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
